// File: rtl/ysyx_22050019_idu_pipe_if.sv
// Decode-stage bus: IFU request, regfile read ports, hazard taps, flush and
// the registered decode bundle toward EXU.
// master = surrounding pipeline (IFU/regfile/EXU side), slave = decode stage.
interface ysyx_22050019_idu_pipe_if #(
    parameter int XLEN      = 64,
    parameter int HAZ_PORTS = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [31:0]            in_inst;
    logic [4:0]             raddr1;
    logic [4:0]             raddr2;
    logic [XLEN-1:0]        rdata1;
    logic [XLEN-1:0]        rdata2;
    logic [HAZ_PORTS-1:0]   haz_valid;
    logic [5*HAZ_PORTS-1:0] haz_rd;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_pc;
    logic [XLEN-1:0]        out_op1;
    logic [XLEN-1:0]        out_op2;
    logic [XLEN-1:0]        out_imm;
    logic [XLEN-1:0]        out_sdata;
    logic [3:0]             out_alu_op;
    logic                   out_word;
    logic [4:0]             out_rd;
    logic                   out_rd_we;
    logic                   out_mem_re;
    logic                   out_mem_we;
    logic [1:0]             out_mem_size;
    logic                   out_mem_unsigned;
    logic [2:0]             out_br_type;
    logic                   out_jal;
    logic                   out_jalr;
    logic                   out_ebreak;
    logic                   out_illegal;

    modport master (
        output in_valid, in_pc, in_inst, rdata1, rdata2, haz_valid, haz_rd, flush, out_ready,
        input  in_ready, raddr1, raddr2, out_valid, out_pc, out_op1, out_op2, out_imm,
               out_sdata, out_alu_op, out_word, out_rd, out_rd_we, out_mem_re, out_mem_we,
               out_mem_size, out_mem_unsigned, out_br_type, out_jal, out_jalr, out_ebreak,
               out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_inst, rdata1, rdata2, haz_valid, haz_rd, flush, out_ready,
        output in_ready, raddr1, raddr2, out_valid, out_pc, out_op1, out_op2, out_imm,
               out_sdata, out_alu_op, out_word, out_rd, out_rd_we, out_mem_re, out_mem_we,
               out_mem_size, out_mem_unsigned, out_br_type, out_jal, out_jalr, out_ebreak,
               out_illegal
    );
endinterface

// File: rtl/ysyx_22050019_idu_pipe.sv
// RV decode stage: one instruction per cycle, RAW-hazard issue blocking,
// flush, single registered output bundle (latency 1).
// Optional macro YSYX_22050019_IDU_PERF_EN adds accept/stall counters.
module ysyx_22050019_idu_pipe #(
    parameter int XLEN      = 64,
    parameter int HAZ_PORTS = 2
) (
    input  logic clk,
    input  logic rst,
    ysyx_22050019_idu_pipe_if.slave bus
`ifdef YSYX_22050019_IDU_PERF_EN
    ,
    output logic [31:0] perf_inst_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LD = 7'b0000011,
                           OPC_ST = 7'b0100011, OPC_OPI = 7'b0010011, OPC_OP = 7'b0110011,
                           OPC_OPI32 = 7'b0011011, OPC_OP32 = 7'b0111011, OPC_SYS = 7'b1110011;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_MUL = 4'd10;
    localparam bit RV64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc, op1, op2, imm, sdata;
        logic [3:0]      alu_op;
        logic            word;
        logic [4:0]      rd;
        logic            rd_we, mem_re, mem_we;
        logic [1:0]      mem_size;
        logic            mem_unsigned;
        logic [2:0]      br_type;
        logic            jal, jalr, ebreak, illegal;
    } bundle_t;

    logic [31:0]     w_inst;
    logic [6:0]      w_opc, w_f7;
    logic [2:0]      w_f3;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt, w_shamt_w;
    logic            w_shf_lo, w_shf_ar, w_use1, w_use2, w_hazard, w_accept;
    bundle_t         w_dec, r_bun;
    logic            r_valid;

    assign w_inst = bus.in_inst;
    assign w_opc  = w_inst[6:0];
    assign w_rd   = w_inst[11:7];
    assign w_f3   = w_inst[14:12];
    assign w_rs1  = w_inst[19:15];
    assign w_rs2  = w_inst[24:20];
    assign w_f7   = w_inst[31:25];

    assign w_imm_i   = XLEN'($signed(w_inst[31:20]));
    assign w_imm_s   = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
    assign w_imm_b   = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
    assign w_imm_u   = XLEN'($signed({w_inst[31:12], 12'b0}));
    assign w_imm_j   = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));
    // RV64 shifts take a 6-bit amount; bit 25 belongs to funct7 on RV32
    assign w_shamt   = RV64 ? XLEN'(w_inst[25:20]) : XLEN'(w_inst[24:20]);
    assign w_shamt_w = XLEN'(w_inst[24:20]);
    assign w_shf_lo  = RV64 ? (w_inst[31:26] == 6'b000000) : (w_f7 == 7'b0000000);
    assign w_shf_ar  = RV64 ? (w_inst[31:26] == 6'b010000) : (w_f7 == 7'b0100000);

    // register-use flags depend on the opcode only, kept apart from rdata to avoid a false loop
    always_comb begin
        w_use1 = !(w_opc == OPC_LUI || w_opc == OPC_AUIPC || w_opc == OPC_JAL);
        w_use2 = (w_opc == OPC_OP || w_opc == OPC_OP32 || w_opc == OPC_BR || w_opc == OPC_ST);
    end

    assign bus.raddr1 = w_use1 ? w_rs1 : 5'd0;
    assign bus.raddr2 = w_use2 ? w_rs2 : 5'd0;

    // RAW check against every downstream writer; x0 is never a dependency
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < HAZ_PORTS; i++) begin
            if (bus.haz_valid[i] && bus.haz_rd[5*i +: 5] != 5'd0 &&
                ((w_use1 && bus.haz_rd[5*i +: 5] == w_rs1) ||
                 (w_use2 && bus.haz_rd[5*i +: 5] == w_rs2)))
                w_hazard = 1'b1;
        end
    end

    assign bus.in_ready = (!r_valid || bus.out_ready) && !w_hazard && !bus.flush;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // instruction decode into the next output bundle
    always_comb begin
        w_dec       = '0;
        w_dec.pc    = bus.in_pc;
        w_dec.sdata = bus.rdata2;
        w_dec.rd    = w_rd;
        case (w_opc)
            OPC_LUI:   begin w_dec.op2 = w_imm_u; w_dec.imm = w_imm_u; w_dec.rd_we = 1'b1; end
            OPC_AUIPC: begin
                w_dec.op1 = bus.in_pc; w_dec.op2 = w_imm_u; w_dec.imm = w_imm_u; w_dec.rd_we = 1'b1;
            end
            OPC_JAL: begin
                w_dec.op1 = bus.in_pc; w_dec.op2 = XLEN'(4); w_dec.imm = w_imm_j;
                w_dec.jal = 1'b1; w_dec.rd_we = 1'b1;
            end
            OPC_JALR: begin
                w_dec.op1 = bus.in_pc; w_dec.op2 = XLEN'(4); w_dec.imm = w_imm_i;
                w_dec.jalr = 1'b1; w_dec.rd_we = 1'b1; w_dec.illegal = (w_f3 != 3'd0);
            end
            OPC_BR: begin
                w_dec.op1 = bus.rdata1; w_dec.op2 = bus.rdata2; w_dec.imm = w_imm_b; w_dec.alu_op = ALU_SUB;
                case (w_f3)
                    3'd0: w_dec.br_type = 3'd1;
                    3'd1: w_dec.br_type = 3'd2;
                    3'd4: w_dec.br_type = 3'd3;
                    3'd5: w_dec.br_type = 3'd4;
                    3'd6: w_dec.br_type = 3'd5;
                    3'd7: w_dec.br_type = 3'd6;
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            OPC_LD: begin
                w_dec.op1 = bus.rdata1; w_dec.op2 = w_imm_i; w_dec.imm = w_imm_i;
                w_dec.mem_re = 1'b1; w_dec.rd_we = 1'b1;
                w_dec.mem_size = w_f3[1:0]; w_dec.mem_unsigned = w_f3[2];
                w_dec.illegal = (w_f3 == 3'd7) || (!RV64 && (w_f3 == 3'd3 || w_f3 == 3'd6));
            end
            OPC_ST: begin
                w_dec.op1 = bus.rdata1; w_dec.op2 = w_imm_s; w_dec.imm = w_imm_s;
                w_dec.mem_we = 1'b1; w_dec.mem_size = w_f3[1:0];
                w_dec.illegal = w_f3[2] || (!RV64 && w_f3 == 3'd3);
            end
            OPC_OPI: begin
                w_dec.op1 = bus.rdata1; w_dec.op2 = w_imm_i; w_dec.imm = w_imm_i; w_dec.rd_we = 1'b1;
                case (w_f3)
                    3'd0: w_dec.alu_op = ALU_ADD;
                    3'd2: w_dec.alu_op = ALU_SLT;
                    3'd3: w_dec.alu_op = ALU_SLTU;
                    3'd4: w_dec.alu_op = ALU_XOR;
                    3'd6: w_dec.alu_op = ALU_OR;
                    3'd7: w_dec.alu_op = ALU_AND;
                    3'd1: begin
                        w_dec.alu_op = ALU_SLL; w_dec.op2 = w_shamt; w_dec.imm = w_shamt;
                        w_dec.illegal = !w_shf_lo;
                    end
                    default: begin
                        w_dec.alu_op = w_shf_ar ? ALU_SRA : ALU_SRL;
                        w_dec.op2 = w_shamt; w_dec.imm = w_shamt;
                        w_dec.illegal = !(w_shf_lo || w_shf_ar);
                    end
                endcase
            end
            OPC_OP: begin
                w_dec.op1 = bus.rdata1; w_dec.op2 = bus.rdata2; w_dec.rd_we = 1'b1;
                case (w_f7)
                    7'b0000000: w_dec.alu_op = (w_f3 == 3'd0) ? ALU_ADD  : (w_f3 == 3'd1) ? ALU_SLL :
                                               (w_f3 == 3'd2) ? ALU_SLT  : (w_f3 == 3'd3) ? ALU_SLTU :
                                               (w_f3 == 3'd4) ? ALU_XOR  : (w_f3 == 3'd5) ? ALU_SRL :
                                               (w_f3 == 3'd6) ? ALU_OR   : ALU_AND;
                    7'b0100000: begin
                        w_dec.alu_op = (w_f3 == 3'd0) ? ALU_SUB : ALU_SRA;
                        w_dec.illegal = !(w_f3 == 3'd0 || w_f3 == 3'd5);
                    end
                    // MULH/MULHSU/MULHU have no ALU code, so only f3=0 and 4..7 decode
                    7'b0000001: begin
                        w_dec.alu_op = (w_f3 == 3'd0) ? ALU_MUL : {2'b11, w_f3[1:0]};
                        w_dec.illegal = !(w_f3 == 3'd0 || w_f3[2]);
                    end
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            OPC_OPI32: begin
                if (!RV64) w_dec.illegal = 1'b1;
                else begin
                    w_dec.op1 = bus.rdata1; w_dec.op2 = w_imm_i; w_dec.imm = w_imm_i;
                    w_dec.rd_we = 1'b1; w_dec.word = 1'b1;
                    case (w_f3)
                        3'd0: w_dec.alu_op = ALU_ADD;
                        3'd1: begin
                            w_dec.alu_op = ALU_SLL; w_dec.op2 = w_shamt_w; w_dec.imm = w_shamt_w;
                            w_dec.illegal = (w_f7 != 7'b0000000);
                        end
                        3'd5: begin
                            w_dec.alu_op = w_inst[30] ? ALU_SRA : ALU_SRL;
                            w_dec.op2 = w_shamt_w; w_dec.imm = w_shamt_w;
                            w_dec.illegal = !(w_f7 == 7'b0000000 || w_f7 == 7'b0100000);
                        end
                        default: w_dec.illegal = 1'b1;
                    endcase
                end
            end
            OPC_OP32: begin
                if (!RV64) w_dec.illegal = 1'b1;
                else begin
                    w_dec.op1 = bus.rdata1; w_dec.op2 = bus.rdata2; w_dec.rd_we = 1'b1; w_dec.word = 1'b1;
                    case (w_f7)
                        7'b0000000: begin
                            w_dec.alu_op = (w_f3 == 3'd0) ? ALU_ADD : (w_f3 == 3'd1) ? ALU_SLL : ALU_SRL;
                            w_dec.illegal = !(w_f3 == 3'd0 || w_f3 == 3'd1 || w_f3 == 3'd5);
                        end
                        7'b0100000: begin
                            w_dec.alu_op = (w_f3 == 3'd0) ? ALU_SUB : ALU_SRA;
                            w_dec.illegal = !(w_f3 == 3'd0 || w_f3 == 3'd5);
                        end
                        7'b0000001: begin
                            w_dec.alu_op = (w_f3 == 3'd0) ? ALU_MUL : {2'b11, w_f3[1:0]};
                            w_dec.illegal = !(w_f3 == 3'd0 || w_f3[2]);
                        end
                        default: w_dec.illegal = 1'b1;
                    endcase
                end
            end
            OPC_SYS: begin
                w_dec.ebreak  = (w_inst == 32'h0010_0073);
                w_dec.illegal = (w_inst != 32'h0010_0073);
            end
            default: w_dec.illegal = 1'b1;
        endcase
        // illegal bundles still flow to EXU but must cause no side effects
        if (w_dec.illegal) begin
            w_dec.rd_we = 1'b0; w_dec.mem_re = 1'b0; w_dec.mem_we = 1'b0;
            w_dec.br_type = 3'd0; w_dec.jal = 1'b0; w_dec.jalr = 1'b0;
        end
        if (w_rd == 5'd0) w_dec.rd_we = 1'b0;
    end

    // output stage: flush beats accept beats drain; otherwise hold bit-stable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_bun   <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_bun   <= w_dec;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_valid        = r_valid;
    assign bus.out_pc           = r_bun.pc;
    assign bus.out_op1          = r_bun.op1;
    assign bus.out_op2          = r_bun.op2;
    assign bus.out_imm          = r_bun.imm;
    assign bus.out_sdata        = r_bun.sdata;
    assign bus.out_alu_op       = r_bun.alu_op;
    assign bus.out_word         = r_bun.word;
    assign bus.out_rd           = r_bun.rd;
    assign bus.out_rd_we        = r_bun.rd_we;
    assign bus.out_mem_re       = r_bun.mem_re;
    assign bus.out_mem_we       = r_bun.mem_we;
    assign bus.out_mem_size     = r_bun.mem_size;
    assign bus.out_mem_unsigned = r_bun.mem_unsigned;
    assign bus.out_br_type      = r_bun.br_type;
    assign bus.out_jal          = r_bun.jal;
    assign bus.out_jalr         = r_bun.jalr;
    assign bus.out_ebreak       = r_bun.ebreak;
    assign bus.out_illegal      = r_bun.illegal;

`ifdef YSYX_22050019_IDU_PERF_EN
    // saturating accept / hazard-stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_accept && perf_inst_cnt != 32'hFFFF_FFFF)
                perf_inst_cnt <= perf_inst_cnt + 32'd1;
            if (bus.in_valid && w_hazard && !bus.flush && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_22050019_idu_pipe.sv
// Scoreboard bench for the decode stage: XLEN=64 instance checked through an
// expected-bundle queue, XLEN=32 instance checked directly for RV64-only encodings.
module tb_ysyx_22050019_idu_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22050019_idu_pipe_if #(.XLEN(64), .HAZ_PORTS(2)) ifa ();
    ysyx_22050019_idu_pipe_if #(.XLEN(32), .HAZ_PORTS(2)) ifb ();

`ifdef YSYX_22050019_IDU_PERF_EN
    logic [31:0] pa_i, pa_s, pb_i, pb_s;
    ysyx_22050019_idu_pipe #(.XLEN(64), .HAZ_PORTS(2)) dut64 (.clk(clk), .rst(rst), .bus(ifa),
                                                              .perf_inst_cnt(pa_i), .perf_stall_cnt(pa_s));
    ysyx_22050019_idu_pipe #(.XLEN(32), .HAZ_PORTS(2)) dut32 (.clk(clk), .rst(rst), .bus(ifb),
                                                              .perf_inst_cnt(pb_i), .perf_stall_cnt(pb_s));
`else
    ysyx_22050019_idu_pipe #(.XLEN(64), .HAZ_PORTS(2)) dut64 (.clk(clk), .rst(rst), .bus(ifa));
    ysyx_22050019_idu_pipe #(.XLEN(32), .HAZ_PORTS(2)) dut32 (.clk(clk), .rst(rst), .bus(ifb));
`endif

    // regfile: x[n] = 5*n
    function automatic logic [63:0] regv(input logic [4:0] a);
        return 64'(a) * 64'd5;
    endfunction
    assign ifa.rdata1 = regv(ifa.raddr1);
    assign ifa.rdata2 = regv(ifa.raddr2);
    assign ifb.rdata1 = 32'(regv(ifb.raddr1));
    assign ifb.rdata2 = 32'(regv(ifb.raddr2));

    typedef struct packed {
        logic [63:0] pc, op1, op2, imm, sdata;
        logic [3:0]  alu;
        logic        word;
        logic [4:0]  rd;
        logic        we, mre, mwe;
        logic [1:0]  sz;
        logic        uns;
        logic [2:0]  br;
        logic        jal, jalr, ebreak, ill;
    } exp_t;

    exp_t q[$];
    exp_t mon_e, mon_g, e;
    int errs = 0;
    int checks = 0;

    function automatic exp_t cur64();
        exp_t g;
        g = '{pc: ifa.out_pc, op1: ifa.out_op1, op2: ifa.out_op2, imm: ifa.out_imm, sdata: ifa.out_sdata,
              alu: ifa.out_alu_op, word: ifa.out_word, rd: ifa.out_rd, we: ifa.out_rd_we,
              mre: ifa.out_mem_re, mwe: ifa.out_mem_we, sz: ifa.out_mem_size, uns: ifa.out_mem_unsigned,
              br: ifa.out_br_type, jal: ifa.out_jal, jalr: ifa.out_jalr, ebreak: ifa.out_ebreak,
              ill: ifa.out_illegal};
        return g;
    endfunction

    function automatic exp_t mk(input logic [63:0] pc, op1, op2, imm, input logic [3:0] alu,
                                input logic [4:0] rd, input logic we);
        exp_t x;
        x = '0;
        x.pc = pc; x.op1 = op1; x.op2 = op2; x.imm = imm; x.alu = alu; x.rd = rd; x.we = we;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor: every handshake on the 64-bit instance pops one expectation
    always @(negedge clk) begin
        if (!rst && ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL bundle: unexpected output pc=%h", ifa.out_pc);
            end else begin
                mon_e = q.pop_front();
                mon_g = cur64();
                if (mon_g !== mon_e) begin
                    errs++;
                    $display("FAIL bundle pc=%h: got %h expected %h", mon_e.pc, mon_g, mon_e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drv(input logic [63:0] pc, input logic [31:0] inst);
        ifa.in_valid = 1'b1; ifa.in_pc = pc; ifa.in_inst = inst;
    endtask

    // present one instruction, queue its expected bundle, wait (bounded) for accept
    task automatic send(input logic [63:0] pc, input logic [31:0] inst, input exp_t x);
        int n;
        drv(pc, inst);
        q.push_back(x);
        n = 0;
        forever begin
            @(negedge clk);
            if (ifa.in_ready) break;
            n++;
            if (n > 20) begin
                checks++; errs++;
                $display("FAIL accept_timeout: pc=%h not accepted, required accept within 20 cycles", pc);
                break;
            end
        end
        step();
        ifa.in_valid = 1'b0;
    endtask

    task automatic drain();
        ifa.out_ready = 1'b1;
        repeat (2) step();
    endtask

    task automatic drvb(input logic [31:0] inst);
        ifb.in_valid = 1'b1; ifb.in_pc = 32'h1000; ifb.in_inst = inst;
        step();
        ifb.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ifa.in_valid = 1'b1; ifa.in_pc = 64'h8000_0000; ifa.in_inst = 32'h0051_0093;
        ifa.haz_valid = '0; ifa.haz_rd = '0; ifa.flush = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_pc = '0; ifb.in_inst = '0;
        ifb.haz_valid = '0; ifb.haz_rd = '0; ifb.flush = 1'b0; ifb.out_ready = 1'b1;

        // reset with in_valid held high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ifa.out_valid), 0);
        checks++;
        if (cur64() !== exp_t'('0)) begin
            errs++;
            $display("FAIL rst_bundle: got %h expected all zero", cur64());
        end
        rst = 1'b0;
        ifa.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(ifa.in_ready), 1);
        chk("rst_no_consume", 64'(ifa.out_valid), 0);
        step();

        // ADDI x1,x2,5
        drv(64'h8000_0000, 32'h0051_0093);
        q.push_back(mk(64'h8000_0000, 10, 5, 5, 4'd0, 5'd1, 1'b1));
        @(negedge clk);
        chk("addi_raddr1", 64'(ifa.raddr1), 2);
        step();
        ifa.in_valid = 1'b0;
        step();

        // assorted encodings through the scoreboard
        send(64'h100, 32'h1234_53B7, mk(64'h100, 0, 64'h1234_5000, 64'h1234_5000, 4'd0, 5'd7, 1'b1)); // LUI
        send(64'h104, 32'h4210_D213, mk(64'h104, 5, 33, 33, 4'd7, 5'd4, 1'b1));                        // SRAI 33
        e = mk(64'h108, 5, 10, 8, 4'd1, 5'd8, 1'b0); e.br = 3'd1; e.sdata = 10;
        send(64'h108, 32'h0020_8463, e);                                                               // BEQ +8
        e = mk(64'h10C, 64'h10C, 4, 16, 4'd0, 5'd1, 1'b1); e.jal = 1'b1;
        send(64'h10C, 32'h0100_00EF, e);                                                               // JAL +16
        e = mk(64'h110, 10, 8, 8, 4'd0, 5'd6, 1'b1); e.mre = 1'b1; e.sz = 2'd3;
        send(64'h110, 32'h0081_3303, e);                                                               // LD
        e = mk(64'h114, 5, 10, 0, 4'd0, 5'd3, 1'b1); e.word = 1'b1; e.sdata = 10;
        send(64'h114, 32'h0020_81BB, e);                                                               // ADDW
        send(64'h118, 32'h0000_0013, mk(64'h118, 0, 0, 0, 4'd0, 5'd0, 1'b0));                          // ADDI x0
        e = mk(64'h11C, 0, 0, 0, 4'd0, 5'd31, 1'b0); e.ill = 1'b1;
        send(64'h11C, 32'hFFFF_FFFF, e);                                                               // illegal
        e = mk(64'h120, 0, 0, 0, 4'd0, 5'd0, 1'b0); e.ebreak = 1'b1;
        send(64'h120, 32'h0010_0073, e);                                                               // EBREAK
        drain();

        // backpressure: SW held stable, ADD waits
        ifa.out_ready = 1'b0;
        e = mk(64'h200, 10, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 4'd0, 5'd28, 1'b0);
        e.mwe = 1'b1; e.sz = 2'd2; e.sdata = 15;
        drv(64'h200, 32'hFE31_2E23);
        q.push_back(e);
        step();
        drv(64'h204, 32'h0031_02B3);
        e = mk(64'h204, 10, 15, 0, 4'd0, 5'd5, 1'b1); e.sdata = 15;
        q.push_back(e);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(ifa.in_ready), 0);
            chk("bp_pc", ifa.out_pc, 64'h200);
            chk("bp_imm", ifa.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
            chk("bp_mem_we", 64'(ifa.out_mem_we), 1);
            chk("bp_size", 64'(ifa.out_mem_size), 2);
            step();
        end
        ifa.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(ifa.in_ready), 1);
        step();
        ifa.in_valid = 1'b0;
        drain();

        // hazard on port 0 (rs1=x2) after a prior bundle
        send(64'h300, 32'h0051_0093, mk(64'h300, 10, 5, 5, 4'd0, 5'd1, 1'b1));
        ifa.haz_valid = 2'b01; ifa.haz_rd = {5'd0, 5'd2};
        drv(64'h304, 32'h0031_02B3);
        @(negedge clk);
        chk("haz_in_ready", 64'(ifa.in_ready), 0);
        step();
        @(negedge clk);
        chk("haz_drained", 64'(ifa.out_valid), 0);
        chk("haz_still_blocked", 64'(ifa.in_ready), 0);
        step();
        ifa.haz_valid = 2'b00;
        e = mk(64'h304, 10, 15, 0, 4'd0, 5'd5, 1'b1); e.sdata = 15;
        q.push_back(e);
        @(negedge clk);
        chk("haz_clear_ready", 64'(ifa.in_ready), 1);
        step();
        // hazard on port 1 (rs2=x3)
        ifa.haz_valid = 2'b10; ifa.haz_rd = {5'd3, 5'd0};
        drv(64'h308, 32'h0031_02B3);
        @(negedge clk);
        chk("haz1_in_ready", 64'(ifa.in_ready), 0);
        step();
        // rs1=x0 with writer on x2: no stall
        ifa.haz_valid = 2'b01; ifa.haz_rd = {5'd0, 5'd2};
        e = mk(64'h30C, 0, 15, 0, 4'd0, 5'd5, 1'b1); e.sdata = 15;
        send(64'h30C, 32'h0030_02B3, e);
        ifa.haz_valid = 2'b00;
        drain();

        // flush kills held bundle and refuses input
        ifa.out_ready = 1'b0;
        drv(64'h400, 32'h0051_0093);
        q.push_back(mk(64'h400, 10, 5, 5, 4'd0, 5'd1, 1'b1));
        step();
        drv(64'h404, 32'h0031_02B3);
        ifa.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(ifa.in_ready), 0);
        step();
        ifa.flush = 1'b0; ifa.in_valid = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        chk("flush_out_valid", 64'(ifa.out_valid), 0);
        @(negedge clk);
        chk("flush_not_consumed", 64'(ifa.out_valid), 0);
        step();

        // reset during backpressure
        drv(64'h500, 32'h0051_0093);
        step();
        drv(64'h504, 32'h0031_02B3);
        rst = 1'b1;
        step();
        rst = 1'b0; ifa.in_valid = 1'b0;
        chk("rst_bp_valid", 64'(ifa.out_valid), 0);
        chk("rst_bp_pc", ifa.out_pc, 0);
        drain();

        // XLEN=32 instance: RV64-only encodings are illegal, shift amount is 5 bits
        drvb(32'h0020_81BB);
        chk("x32_addw_valid", 64'(ifb.out_valid), 1);
        chk("x32_addw_illegal", 64'(ifb.out_illegal), 1);
        chk("x32_addw_we", 64'(ifb.out_rd_we), 0);
        drvb(32'h0081_3303);
        chk("x32_ld_illegal", 64'(ifb.out_illegal), 1);
        chk("x32_ld_re", 64'(ifb.out_mem_re), 0);
        drvb(32'h41F0_D213);
        chk("x32_srai_illegal", 64'(ifb.out_illegal), 0);
        chk("x32_srai_alu", 64'(ifb.out_alu_op), 7);
        chk("x32_srai_op2", 64'(ifb.out_op2), 31);
        chk("x32_srai_op1", 64'(ifb.out_op1), 5);
        drvb(32'h4210_D213);
        chk("x32_srai_bit25_illegal", 64'(ifb.out_illegal), 1);

        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 20) begin
                @(posedge clk);
                n++;
            end
        end
        chk("sb_empty", 64'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_22050019_idu_pipe.md
Name: ysyx_22050019_idu_pipe

Overview:
Pipelined, parametrised RV decode stage sitting between the IFU and EXU. It accepts one instruction per cycle over a valid/ready handshake and reads operands from the regfile through combinational read ports. It blocks issue on RAW hazards against in-flight writers and supports flush. Results go to a registered output stage; branch resolution is left to EXU.

Parameters:
XLEN, 64, datapath width; 32 or 64. At 32, OP-32/OP-IMM-32 opcodes and LD/LWU/SD decode as illegal.
HAZ_PORTS, 2, number of downstream writer stages checked for RAW hazards.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IFU instruction valid
in_ready  out  1  decode can accept
in_pc  in  XLEN  instruction PC
in_inst  in  32  instruction word
raddr1 / raddr2  out  5  regfile read indices; rs1/rs2 when used, else 0
rdata1 / rdata2  in  XLEN  regfile read data, combinational from raddr
haz_valid  in  HAZ_PORTS  writer stage i holds a pending write
haz_rd  in  5*HAZ_PORTS  rd of writer stage i (slice i = [5i+4:5i])
flush  in  1  kill the held output and refuse input this cycle
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU accepts
out_pc, out_op1, out_op2, out_imm, out_sdata  out  XLEN  PC, ALU operands, sign-extended immediate, store data (rdata2)
out_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 12 DIV, 13 DIVU, 14 REM, 15 REMU
out_word  out  1  32-bit op with sign-extended result (W ops; only when XLEN=64)
out_rd  out  5  destination register
out_rd_we  out  1  write-back enable; forced 0 when rd=0
out_mem_re / out_mem_we  out  1  load / store
out_mem_size  out  2  0 B, 1 H, 2 W, 3 D
out_mem_unsigned  out  1  LBU/LHU/LWU
out_br_type  out  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU
out_jal / out_jalr  out  1  jump kinds
out_ebreak  out  1  inst == 0x00100073
out_illegal  out  1  unrecognised encoding

Behaviour:
- Reset: out_valid=0. Every out_* bundle register is 0. in_ready is combinational and reads 1 after reset.
- Decoded fields come from in_inst and are captured into the output registers on accept. Latency is 1 cycle.
- Definitions:
  - hazard = any i where haz_valid[i] && haz_rd[i]!=0 && ((uses_rs1 && haz_rd[i]==rs1) || (uses_rs2 && haz_rd[i]==rs2)).
  - x0 never hazards.
  - uses_rs1 is set for all types except LUI/AUIPC/JAL.
  - uses_rs2 is set for R, OP-32, branch and store.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- State (out_valid) each cycle, in priority order:
  - flush: out_valid<=0.
  - else in_valid && in_ready: load bundle, out_valid<=1.
  - else out_ready: out_valid<=0 (bubble).
  - else hold. While out_valid && !out_ready, all out_* stay bit-stable.
- Operand selection:
  - LUI: op1=0, op2=imm.
  - AUIPC: op1=pc, op2=imm.
  - JAL/JALR: op1=pc, op2=4, ALU ADD.
  - OP-IMM, load, store: op1=rdata1, op2=imm.
  - R and branch: op1=rdata1, op2=rdata2.
- Immediates are sign-extended to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Shift-immediate amount is inst[25:20] for XLEN=64 and inst[24:20] for XLEN=32. SRAI/SRAIW are selected by inst[30].
- Illegal: any unknown opcode, funct3 or funct7 combination. Then out_illegal=1, rd_we=0, mem_re=mem_we=0, br_type=0; the bundle is still delivered.
- Loads and stores use ALU ADD. Store data is rdata2. JALR target computation is done in EXU from op1/imm.
- rst asserted mid-stall or mid-backpressure returns to the reset state next cycle. No bundle is delivered.

Optional Feature:
- Macro YSYX_22050019_IDU_PERF_EN. When defined, adds outputs perf_inst_cnt[31:0] and perf_stall_cnt[31:0].
- perf_inst_cnt increments on each accept.
- perf_stall_cnt increments on each cycle with in_valid && hazard && !flush.
- Both counters saturate at 0xFFFFFFFF and clear on rst.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, all out_* 0, in_ready=1 after release with no hazard.
- ADDI x1,x2,5 (0x00510093), rdata1=10, out_ready=1 -> next cycle out_valid=1, op1=10, op2=5, alu_op=0, rd=1, rd_we=1, raddr1=2.
- Backpressure: issue SW x3,-4(x2) (0xFE312E23) then ADD, with out_ready=0 -> store bundle held stable, imm=-4, mem_we=1, size=2, in_ready=0. Raise out_ready -> ADD is accepted that cycle.
- Hazard: haz_valid=01, haz_rd[4:0]=2, inst ADD x5,x2,x3 -> in_ready=0 and out_valid falls to 0 after the prior bundle drains. Drop haz_valid -> accepted next cycle. Same stimulus with rs1=x0 -> no stall.
- Flush: out_valid=1, out_ready=0, in_valid=1, flush=1 -> next cycle out_valid=0, input not consumed.
- XLEN=32 instance: ADDW (0x002081BB) -> out_illegal=1, rd_we=0. Same word at XLEN=64 -> alu_op=0, out_word=1, legal.
